// File: rtl/id_hazard_ctrl_pkg.sv
// Shared core definitions for the ID-stage hazard controller: register-index
// width, FSM state encoding and the bundle of pipeline control strobes.
package id_hazard_ctrl_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_write;
        logic pc_sel;
        logic ifid_write;
        logic ifid_flush;
        logic idex_write;
        logic idex_bubble;
        logic exmem_flush;
        logic exmem_write;
        logic memwb_bubble;
    } ctrl_t;

    // Normal flow: every pipeline register advances, nothing is squashed.
    function automatic ctrl_t ctrl_default();
        ctrl_t c;
        c              = '0;
        c.pc_write     = 1'b1;
        c.ifid_write   = 1'b1;
        c.idex_write   = 1'b1;
        c.exmem_write  = 1'b1;
        return c;
    endfunction

    // Whole front end frozen; MEM/WB receives a NOP so nothing retires twice.
    function automatic ctrl_t ctrl_freeze();
        ctrl_t c;
        c              = '0;
        c.memwb_bubble = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts qualifying cycles and sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] value
);

    // Increment on request unless already saturated; never wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= '0;
        end else if (inc && (value != {W{1'b1}})) begin
            value <= value + W'(1);
        end
    end

endmodule

// File: rtl/id_hazard_ctrl.sv
// Pipeline hazard controller: resolves memory waits, control-flow redirects
// and load-use hazards into stall/flush strobes, and keeps event counters.
module id_hazard_ctrl
    import id_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [REG_W-1:0] i_rdReg1,
    input  logic [REG_W-1:0] i_rdReg2,
    input  logic             i_exMemRead,
    input  logic [REG_W-1:0] i_exRd,
    input  logic             i_redirect,
    input  logic             i_memReq,
    input  logic             i_memReady,
    output logic             o_pcWrite,
    output logic             o_pcSel,
    output logic             o_ifidWrite,
    output logic             o_ifidFlush,
    output logic             o_idexWrite,
    output logic             o_idexBubble,
    output logic             o_exmemFlush,
    output logic             o_exmemWrite,
    output logic             o_memwbBubble,
    output logic             o_err,
    output logic [CNT_W-1:0] o_cntLoadUse,
    output logic [CNT_W-1:0] o_cntFlush,
    output logic [CNT_W-1:0] o_cntMemWait
);

    localparam int WC_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W:0] TIMEOUT_V = (WC_W + 1)'(MEM_TIMEOUT);

    state_t          state;
    state_t          state_nxt;
    logic [WC_W-1:0] wait_cnt;
    logic [WC_W:0]   wait_inc;
    logic            timeout_hit;
    logic            in_error;
    logic            mem_wait;
    logic            redirect_act;
    logic            load_use_hit;
    logic            load_use_act;
    ctrl_t           ctrl;

    // Event qualification, highest priority first; lower events are masked.
    assign in_error     = (state == ST_ERROR);
    assign mem_wait     = !in_error && i_memReq && !i_memReady;
    assign redirect_act = !in_error && !mem_wait && i_redirect;
    assign load_use_hit = i_exMemRead && (i_exRd != '0) &&
                          (((i_rdReg1 != '0) && (i_rdReg1 == i_exRd)) ||
                           ((i_rdReg2 != '0) && (i_rdReg2 == i_exRd)));
    assign load_use_act = !in_error && !mem_wait && !i_redirect && load_use_hit;

    // The wait that brings the consecutive count up to the limit is the last one.
    assign wait_inc    = {1'b0, wait_cnt} + {{WC_W{1'b0}}, 1'b1};
    assign timeout_hit = (wait_inc == TIMEOUT_V);

    // State register; reset abandons any wait or error.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN, ST_MEM_WAIT: begin
                if (mem_wait) begin
                    state_nxt = timeout_hit ? ST_ERROR : ST_MEM_WAIT;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_ERROR: state_nxt = ST_ERROR;
            default:  state_nxt = ST_RUN;
        endcase
    end

    // Consecutive wait-cycle counter; cleared whenever the FSM lands in RUN.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wait_cnt <= '0;
        end else if (state_nxt == ST_RUN) begin
            wait_cnt <= '0;
        end else if (mem_wait) begin
            wait_cnt <= wait_inc[WC_W-1:0];
        end
    end

    // Output logic: zero-latency strobes from state and current inputs.
    always_comb begin
        ctrl = ctrl_default();
        if (in_error || mem_wait) begin
            ctrl = ctrl_freeze();
        end else if (redirect_act) begin
            ctrl.pc_sel      = 1'b1;
            ctrl.pc_write    = 1'b1;
            ctrl.ifid_flush  = 1'b1;
            ctrl.idex_bubble = 1'b1;
            ctrl.exmem_flush = 1'b1;
        end else if (load_use_act) begin
            ctrl.pc_write    = 1'b0;
            ctrl.ifid_write  = 1'b0;
            ctrl.idex_bubble = 1'b1;
        end
    end

    assign o_pcWrite     = ctrl.pc_write;
    assign o_pcSel       = ctrl.pc_sel;
    assign o_ifidWrite   = ctrl.ifid_write;
    assign o_ifidFlush   = ctrl.ifid_flush;
    assign o_idexWrite   = ctrl.idex_write;
    assign o_idexBubble  = ctrl.idex_bubble;
    assign o_exmemFlush  = ctrl.exmem_flush;
    assign o_exmemWrite  = ctrl.exmem_write;
    assign o_memwbBubble = ctrl.memwb_bubble;
    assign o_err         = in_error;

    sat_counter #(.W(CNT_W)) u_cnt_load_use (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .inc   (load_use_act),
        .value (o_cntLoadUse)
    );

    sat_counter #(.W(CNT_W)) u_cnt_flush (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .inc   (redirect_act),
        .value (o_cntFlush)
    );

    sat_counter #(.W(CNT_W)) u_cnt_mem_wait (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .inc   (mem_wait),
        .value (o_cntMemWait)
    );

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: small build (timeout 4, 4-bit counters),
// directed scenarios followed by randomized traffic.
module tb_id_hazard_ctrl;

    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    // {pcWrite,pcSel,ifidWrite,ifidFlush,idexWrite,idexBubble,exmemFlush,exmemWrite,memwbBubble,err}
    localparam logic [9:0] V_DEF = 10'b1010100100;
    localparam logic [9:0] V_FRZ = 10'b0000000010;
    localparam logic [9:0] V_ERR = 10'b0000000011;
    localparam logic [9:0] V_RED = 10'b1111111100;
    localparam logic [9:0] V_LU  = 10'b0000110100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    rd1 = '0, rd2 = '0, exrd = '0;
    logic          exmr = 1'b0, redir = 1'b0, mreq = 1'b0, mrdy = 1'b0;
    logic          pc_write, pc_sel, ifid_write, ifid_flush, idex_write;
    logic          idex_bubble, exmem_flush, exmem_write, memwb_bubble, err;
    logic [CW-1:0] cnt_lu, cnt_fl, cnt_mw;

    typedef struct {
        logic [9:0] ctrl;
        int         lu;
        int         fl;
        int         mw;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference state: sticky error flag, run of consecutive waits, event totals.
    bit   m_err = 0;
    int   m_waits = 0;
    int   m_lu = 0, m_fl = 0, m_mw = 0;

    always #5 clk = ~clk;

    id_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_rdReg1      (rd1),
        .i_rdReg2      (rd2),
        .i_exMemRead   (exmr),
        .i_exRd        (exrd),
        .i_redirect    (redir),
        .i_memReq      (mreq),
        .i_memReady    (mrdy),
        .o_pcWrite     (pc_write),
        .o_pcSel       (pc_sel),
        .o_ifidWrite   (ifid_write),
        .o_ifidFlush   (ifid_flush),
        .o_idexWrite   (idex_write),
        .o_idexBubble  (idex_bubble),
        .o_exmemFlush  (exmem_flush),
        .o_exmemWrite  (exmem_write),
        .o_memwbBubble (memwb_bubble),
        .o_err         (err),
        .o_cntLoadUse  (cnt_lu),
        .o_cntFlush    (cnt_fl),
        .o_cntMemWait  (cnt_mw)
    );

    function automatic int sat_inc(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, expv);
        end
    endtask

    // One clock of stimulus; the expected response for that cycle is queued.
    task automatic step(input logic rst, input logic [4:0] r1, input logic [4:0] r2,
                        input logic emr, input logic [4:0] erd, input logic rdr,
                        input logic req, input logic rdy);
        exp_t e;
        bit   hazard;
        @(posedge clk);
        #1;
        rst_n = rst; rd1 = r1; rd2 = r2; exmr = emr; exrd = erd;
        redir = rdr; mreq = req; mrdy = rdy;
        if (!rst) begin
            m_err = 0; m_waits = 0; m_lu = 0; m_fl = 0; m_mw = 0;
        end else begin
            e.lu = m_lu; e.fl = m_fl; e.mw = m_mw;
            hazard = emr && (erd != 0) && ((r1 == erd) || (r2 == erd));
            if (m_err) begin
                e.ctrl = V_ERR;
            end else if (req && !rdy) begin
                e.ctrl  = V_FRZ;
                m_mw    = sat_inc(m_mw);
                m_waits = m_waits + 1;
                if (m_waits >= TO) m_err = 1;
            end else begin
                m_waits = 0;
                if (rdr) begin
                    e.ctrl = V_RED;
                    m_fl   = sat_inc(m_fl);
                end else if (hazard) begin
                    e.ctrl = V_LU;
                    m_lu   = sat_inc(m_lu);
                end else begin
                    e.ctrl = V_DEF;
                end
            end
            q.push_back(e);
        end
    endtask

    task automatic idle();
        step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Compare every presented cycle against the queued expectation.
    initial begin
        exp_t e;
        logic [9:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {pc_write, pc_sel, ifid_write, ifid_flush, idex_write,
                       idex_bubble, exmem_flush, exmem_write, memwb_bubble, err};
                chk("ctrl", int'(act), int'(e.ctrl));
                chk("cntLoadUse", int'(cnt_lu), e.lu);
                chk("cntFlush", int'(cnt_fl), e.fl);
                chk("cntMemWait", int'(cnt_mw), e.mw);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(); do_reset();
        idle();

        // Load-use on rs2
        step(1'b1, 5'd0, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        idle();

        // Load targeting x0 is never a hazard
        step(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        idle();

        // Redirect wins over a simultaneous load-use
        do_reset();
        step(1'b1, 5'd7, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        idle();

        // Three-cycle memory wait then completion; redirect held through it
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 5'd3, 5'd0, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
        step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        idle();
        for (int i = 0; i < 3; i++) step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
        idle();

        // Timeout into sticky error, then reset recovers
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b1, 5'd1, 5'd0, 1'b1, 5'd1, 1'b1, 1'b1, 1'b1);
        do_reset();
        idle();

        // Flush counter saturation
        do_reset();
        for (int i = 0; i < (1 << CW) + 1; i++) step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        idle();

        // Randomized traffic with occasional resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic req;
            req = ($urandom_range(0, 9) < 4);
            step(($urandom_range(0, 39) != 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0), req,
                 ($urandom_range(0, 9) < 6));
        end

        @(posedge clk);
        @(posedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_hazard_ctrl.md
ID_HAZARD_CTRL -- requirements
Module: id_hazard_ctrl

Interface
REQ-001 Parameters SHALL be: MEM_TIMEOUT, 255, maximum consecutive memory-wait cycles before error; CNT_W, 16, width of each performance counter.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  i_clk  in  1  core clock; single clock domain
  i_rst_n  in  1  reset; synchronous, active-low
  i_rdReg1  in  5  ID-stage source register 1; 0 means unused
  i_rdReg2  in  5  ID-stage source register 2; 0 means unused
  i_exMemRead  in  1  EX-stage instruction is a load
  i_exRd  in  5  EX-stage destination register
  i_redirect  in  1  MEM-stage taken branch or jump
  i_memReq  in  1  MEM-stage load or store active
  i_memReady  in  1  data memory completes the request this cycle
  o_pcWrite  out  1  PC register enable
  o_pcSel  out  1  1 = load redirect target into PC
  o_ifidWrite  out  1  IF/ID register enable
  o_ifidFlush  out  1  IF/ID becomes NOP
  o_idexWrite  out  1  ID/EX register enable
  o_idexBubble  out  1  ID/EX loads NOP (all control zero)
  o_exmemFlush  out  1  EX/MEM loads NOP
  o_exmemWrite  out  1  EX/MEM register enable
  o_memwbBubble  out  1  MEM/WB loads NOP
  o_err  out  1  memory timeout; sticky until reset
  o_cntLoadUse  out  CNT_W  load-use stall cycles
  o_cntFlush  out  CNT_W  redirect events
  o_cntMemWait  out  CNT_W  memory wait cycles

Function
REQ-003 FSM states SHALL be RUN, MEM_WAIT, ERROR; the state SHALL be registered and all control outputs SHALL be combinational from state and inputs (zero-cycle latency).
REQ-004 Default (no event): all enables 1, all flush/bubble/pcSel 0.
REQ-005 Memory wait: when i_memReq=1 and i_memReady=0 in RUN or MEM_WAIT, o_pcWrite, o_ifidWrite, o_idexWrite, and o_exmemWrite SHALL be 0 and o_memwbBubble SHALL be 1; the next state SHALL be MEM_WAIT.
REQ-006 In MEM_WAIT, i_memReady=1 SHALL produce default outputs that cycle and return to RUN; a wait-cycle counter SHALL clear on entry to RUN.
REQ-007 When the wait-cycle counter reaches MEM_TIMEOUT, the next state SHALL be ERROR; ERROR SHALL hold all enables at 0, o_memwbBubble at 1, and o_err at 1 until reset.
REQ-008 Redirect (i_redirect=1, no memory wait): o_pcSel=1, o_pcWrite=1, o_ifidFlush=1, o_idexBubble=1, o_exmemFlush=1 for exactly that cycle.
REQ-009 Load-use (i_exMemRead=1, i_exRd!=0, i_exRd equal to a nonzero i_rdReg1 or i_rdReg2, no redirect, no memory wait): o_pcWrite=0, o_ifidWrite=0, o_idexBubble=1 for that cycle.
REQ-010 Priority SHALL be ERROR > memory wait > redirect > load-use; a lower-priority event coinciding with a higher one SHALL be suppressed and not counted. A redirect held during a memory wait takes effect in the i_memReady cycle.
REQ-011 Counters SHALL increment by 1 per qualifying cycle, saturate at all-ones, and never wrap. o_cntLoadUse counts REQ-009 cycles, o_cntFlush counts REQ-008 cycles, and o_cntMemWait counts REQ-005 cycles.

Reset
REQ-012 When i_rst_n=0 at a rising edge of i_clk: state SHALL be RUN, all counters 0, and o_err 0; outputs SHALL be defaults. Reset mid-wait SHALL abandon MEM_WAIT or ERROR.

Structure
REQ-013 The FSM state enum and the register-index width (5) SHALL live in the shared core package.
REQ-014 One sub-module, sat_counter (parameter W; ports clock, reset, increment, value), SHALL be instantiated three times.

Verification
REQ-015 i_exMemRead=1, i_exRd=5, i_rdReg2=5 -> one cycle with o_pcWrite=0, o_idexBubble=1; o_cntLoadUse=1.
REQ-016 i_exRd=0 with i_rdReg1=0 and i_exMemRead=1 -> no stall.
REQ-017 i_redirect plus a load-use condition in the same cycle -> o_pcSel=1 and flushes asserted; o_cntFlush=1; o_cntLoadUse=0.
REQ-018 i_memReq=1 with i_memReady low for 3 cycles -> 3 frozen cycles, default outputs on the 4th, o_cntMemWait=3.
REQ-019 MEM_TIMEOUT=4 with i_memReady held low -> o_err=1 from the cycle after the 4th wait cycle, persisting while i_memReady later rises; reset clears it.
REQ-020 Preload o_cntFlush to saturation via 2^CNT_W redirects (CNT_W=4 build) -> value stays 15.
